// File: rtl/delta_outlier_encoder.sv
// Delta/outlier encoder: codes per-element temporal deltas as small signed inliers,
// spilling deltas that do not fit into an indexed full-width outlier FIFO.
module delta_outlier_encoder #(
  parameter int VEC_LEN   = 128,
  parameter int DATA_W    = 32,
  parameter int INLIER_W  = 4,
  parameter int THRESH    = 7,
  parameter int OFL_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INLIER_W-1:0]          out_inlier,
  output logic                         out_flag,
  output logic                         out_last,
  output logic                         ofl_valid,
  input  logic                         ofl_ready,
  output logic [DATA_W:0]              ofl_delta,
  output logic [$clog2(VEC_LEN)-1:0]   ofl_index,
  output logic                         frame_done,
  output logic [$clog2(VEC_LEN):0]     ofl_count,
  output logic                         err_len
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PTR_W = $clog2(OFL_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + DATA_W + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [DATA_W:0] POS_T   = (DATA_W + 1)'(THRESH);
  localparam logic signed [DATA_W:0] NEG_T   = -POS_T;

  logic [DATA_W-1:0]   prev_q [VEC_LEN];
  logic [DATA_W-1:0]   prev_d [VEC_LEN];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [INLIER_W-1:0] out_inlier_q, out_inlier_d;
  logic                out_flag_q, out_flag_d;
  logic                out_last_q, out_last_d;
  logic                err_len_q, err_len_d;
  logic [IDX_W:0]      ofl_count_q, ofl_count_d;
  logic [ENT_W-1:0]    mem_q [OFL_DEPTH];
  logic [ENT_W-1:0]    mem_d [OFL_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic                fifo_full;
  logic                accept;
  logic                clear_eff;
  logic                is_last_idx;
  logic [DATA_W-1:0]   prev_sel;
  logic signed [DATA_W:0] delta;
  logic                is_outlier;
  logic                push;
  logic                pop;

  assign fifo_full   = (fifo_cnt_q == CNT_W'(OFL_DEPTH));
  assign in_ready    = (!out_valid_q || out_ready) && !fifo_full;
  assign accept      = in_valid && in_ready;
  assign clear_eff   = clear && (idx_q == '0);
  assign is_last_idx = (idx_q == LAST_IDX);
  assign prev_sel    = clear_eff ? '0 : prev_q[idx_q];
  // One extra bit keeps the difference of two full-range values exact.
  assign delta       = {in_data[DATA_W-1], in_data} - {prev_sel[DATA_W-1], prev_sel};
  assign is_outlier  = (delta > POS_T) || (delta < NEG_T);
  assign push        = accept && is_outlier;
  assign pop         = ofl_valid && ofl_ready;

  always_comb begin
    prev_d = prev_q;
    if (clear_eff) begin
      for (int i = 0; i < VEC_LEN; i++) prev_d[i] = '0;
    end
    if (accept) prev_d[idx_q] = in_data;

    idx_d     = idx_q;
    err_len_d = 1'b0;
    if (accept) begin
      if (in_last && !is_last_idx) idx_d = '0;
      else                         idx_d = idx_q + 1'b1;
      err_len_d = in_last ^ is_last_idx;
    end

    out_valid_d  = out_valid_q;
    out_inlier_d = out_inlier_q;
    out_flag_d   = out_flag_q;
    out_last_d   = out_last_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_inlier_d = is_outlier ? '0 : delta[INLIER_W-1:0];
      out_flag_d   = is_outlier;
      out_last_d   = is_last_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end

    // The first beat of a frame restarts the outlier tally, including itself.
    ofl_count_d = ofl_count_q;
    if (accept && idx_q == '0) ofl_count_d = {{IDX_W{1'b0}}, push};
    else if (push)             ofl_count_d = ofl_count_q + 1'b1;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {idx_q, delta};
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '{default: '0};
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_inlier_q <= '0;
      out_flag_q   <= 1'b0;
      out_last_q   <= 1'b0;
      err_len_q    <= 1'b0;
      ofl_count_q  <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_inlier_q <= out_inlier_d;
      out_flag_q   <= out_flag_d;
      out_last_q   <= out_last_d;
      err_len_q    <= err_len_d;
      ofl_count_q  <= ofl_count_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inlier = out_inlier_q;
  assign out_flag   = out_flag_q;
  assign out_last   = out_last_q;
  assign err_len    = err_len_q;
  assign ofl_count  = ofl_count_q;
  assign frame_done = out_valid_q && out_ready && out_last_q;
  // Head fields are masked so an empty FIFO presents zeros.
  assign ofl_valid  = (fifo_cnt_q != '0);
  assign ofl_delta  = ofl_valid ? mem_q[rd_ptr_q][DATA_W:0] : '0;
  assign ofl_index  = ofl_valid ? mem_q[rd_ptr_q][ENT_W-1 -: IDX_W] : '0;

endmodule

// File: tb/tb_delta_outlier_encoder.sv
// Directed bench for delta_outlier_encoder: hand-computed codes, stalls, FIFO
// backpressure, frame length errors and mid-frame reset.
module tb_delta_outlier_encoder;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_inlier;
  logic        out_flag;
  logic        out_last;
  logic        ofl_valid;
  logic        ofl_ready;
  logic [32:0] ofl_delta;
  logic [6:0]  ofl_index;
  logic        frame_done;
  logic [7:0]  ofl_count;
  logic        err_len;

  int vectors;
  int miscompares;
  int fd_total;
  int fd_base;
  int exp_idx;
  int guard;

  delta_outlier_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inlier (out_inlier),
    .out_flag   (out_flag),
    .out_last   (out_last),
    .ofl_valid  (ofl_valid),
    .ofl_ready  (ofl_ready),
    .ofl_delta  (ofl_delta),
    .ofl_index  (ofl_index),
    .frame_done (frame_done),
    .ofl_count  (ofl_count),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial fd_total = 0;
  always @(posedge clk) begin
    if (frame_done) fd_total <= fd_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the encoder takes it.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int wait_cnt;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL accept_timeout: in_ready 0 after 50 cycles, required 1");
    end
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    ofl_ready   = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_ofl_valid", ofl_valid, 0);
    checkOutput("rst_ofl_count", ofl_count, 0);
    checkOutput("rst_err_len", err_len, 0);

    // Case 1: clear + data 5 at idx 0
    rst_n = 1'b1;
    clear = 1'b1;
    applyStimulus(32'd5, 1'b0);
    clear = 1'b0;
    checkOutput("c1_out_valid", out_valid, 1);
    checkOutput("c1_out_inlier", out_inlier, 4'b0101);
    checkOutput("c1_out_flag", out_flag, 0);
    checkOutput("c1_ofl_valid", ofl_valid, 0);
    for (int i = 1; i < 128; i++) applyStimulus(32'd0, i == 127);
    checkOutput("c1_out_last", out_last, 1);
    checkOutput("c1_frame_done", frame_done, 1);
    checkOutput("c1_no_err", err_len, 0);

    // Case 2: -3 against prev 5 gives delta -8, an outlier
    applyStimulus(-32'sd3, 1'b0);
    checkOutput("c2_out_flag", out_flag, 1);
    checkOutput("c2_out_inlier", out_inlier, 0);
    checkOutput("c2_ofl_valid", ofl_valid, 1);
    checkOutput("c2_ofl_index", ofl_index, 0);
    checkOutput("c2_ofl_delta", ofl_delta, 33'h1FFFFFFF8);
    checkOutput("c2_ofl_count", ofl_count, 1);
    in_valid  = 1'b0;
    ofl_ready = 1'b1;
    tick();
    ofl_ready = 1'b0;
    checkOutput("c2_popped", ofl_valid, 0);

    // Case 3: downstream stall holds one beat, then beats resume in order
    out_ready = 1'b0;
    applyStimulus(32'd1, 1'b0);
    in_data  = 32'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("c3_in_ready", in_ready, 0);
      checkOutput("c3_held", out_inlier, 4'd1);
      tick();
    end
    out_ready = 1'b1;
    applyStimulus(32'd2, 1'b0);
    checkOutput("c3_beat2", out_inlier, 4'd2);
    applyStimulus(32'd3, 1'b0);
    checkOutput("c3_beat3", out_inlier, 4'd3);
    idle();

    // Case 4: outlier FIFO fills after 16 pushes at idx 4..19
    for (int i = 0; i < 16; i++) applyStimulus(32'd100, 1'b0);
    in_data  = 32'd100;
    in_valid = 1'b1;
    #1;
    checkOutput("c4_full_in_ready", in_ready, 0);
    checkOutput("c4_ofl_count", ofl_count, 17);
    checkOutput("c4_head_index", ofl_index, 4);
    checkOutput("c4_head_delta", ofl_delta, 33'd100);
    tick();
    checkOutput("c4_still_blocked", in_ready, 0);
    ofl_ready = 1'b1;
    tick();
    ofl_ready = 1'b0;
    checkOutput("c4_in_ready_back", in_ready, 1);
    checkOutput("c4_head_after_pop", ofl_index, 5);
    tick();
    in_valid  = 1'b0;
    ofl_ready = 1'b1;
    exp_idx   = 5;
    guard     = 0;
    while (ofl_valid && guard < 40) begin
      checkOutput("c4_drain_index", ofl_index, exp_idx);
      exp_idx++;
      guard++;
      tick();
    end
    checkOutput("c4_drain_total", exp_idx, 21);
    ofl_ready = 1'b0;

    // Case 5: finish frame, then in_last early at idx 5
    for (int i = 21; i < 128; i++) applyStimulus(32'd0, i == 127);
    applyStimulus(-32'sd3, 1'b0);
    applyStimulus(32'd1, 1'b0);
    applyStimulus(32'd2, 1'b0);
    applyStimulus(32'd3, 1'b0);
    applyStimulus(32'd100, 1'b0);
    applyStimulus(32'd100, 1'b1);
    checkOutput("c5_err_len", err_len, 1);
    checkOutput("c5_no_outlier", ofl_valid, 0);
    fd_base = fd_total;
    applyStimulus(32'd50, 1'b0);
    checkOutput("c5_err_pulse_end", err_len, 0);
    checkOutput("c5_idx0_valid", ofl_valid, 1);
    checkOutput("c5_idx0_index", ofl_index, 0);
    checkOutput("c5_idx0_delta", ofl_delta, 33'd53);
    checkOutput("c5_idx0_count", ofl_count, 1);
    ofl_ready = 1'b1;
    for (int i = 1; i < 128; i++) applyStimulus(32'd0, i == 127);
    idle();
    checkOutput("c5_frame_done_once", fd_total - fd_base, 1);

    // Case 6: reset at idx 40 with a non-empty FIFO
    for (int i = 0; i < 40; i++) applyStimulus(-32'sd50, 1'b0);
    checkOutput("c6_pre_ofl_valid", ofl_valid, 1);
    checkOutput("c6_pre_ofl_count", ofl_count, 40);
    in_data  = -32'sd50;
    in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("c6_rst_out_valid", out_valid, 0);
    checkOutput("c6_rst_in_ready", in_ready, 1);
    checkOutput("c6_rst_ofl_valid", ofl_valid, 0);
    checkOutput("c6_rst_ofl_delta", ofl_delta, 0);
    checkOutput("c6_rst_ofl_count", ofl_count, 0);
    checkOutput("c6_rst_out_flag", out_flag, 0);
    checkOutput("c6_rst_frame_done", frame_done, 0);
    tick();
    rst_n     = 1'b1;
    ofl_ready = 1'b0;
    applyStimulus(32'd6, 1'b0);
    checkOutput("c6_post_inlier", out_inlier, 4'd6);
    checkOutput("c6_post_flag", out_flag, 0);
    applyStimulus(32'd20, 1'b0);
    checkOutput("c6_post_ofl_index", ofl_index, 1);
    checkOutput("c6_post_ofl_delta", ofl_delta, 33'd20);
    checkOutput("c6_post_ofl_count", ofl_count, 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
